// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the zero-register index and operand types for the register file, PC and decode blocks
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with r0 forcing; the write-through compare exists only when REGFILE_BYPASS_EN is defined
module regfile_read_port
   import regfile_pkg::*;
(
   input  reg_addr_t addr,
   input  reg_data_t regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
   input  logic      write,
   input  reg_addr_t we,
   input  reg_data_t writeData,
`endif
   output reg_data_t data
);
`ifdef REGFILE_BYPASS_EN
   // r0 reads zero first, then an in-flight write to this address is forwarded, else the stored value
   always_comb data = (addr == ZERO_REG) ? '0 : (write && we != ZERO_REG && we == addr) ? writeData : regs[addr];
`else
   // r0 reads zero, everything else comes straight from storage
   always_comb data = (addr == ZERO_REG) ? '0 : regs[addr];
`endif
endmodule

// File: rtl/register_file.sv
// register_file: MIPS32 32x32 register file, two combinational read ports, one write port; REGFILE_BYPASS_EN enables write-through forwarding
module register_file
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  reg_addr_t rs,
   input  reg_addr_t ra,
   input  reg_addr_t we,
   input  reg_data_t writeData,
   input  logic      write,
   output reg_data_t readDatars,
   output reg_data_t readDatara
);
   reg_data_t regs [NUM_REGS];
   // Asynchronous clear of all registers; writes to r0 are dropped so it stays zero forever
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end
      else if (write && we != ZERO_REG) regs[we] <= writeData;
   regfile_read_port portRs (
      .addr(rs),
      .regs(regs),
`ifdef REGFILE_BYPASS_EN
      .write(write),
      .we(we),
      .writeData(writeData),
`endif
      .data(readDatars)
   );
   regfile_read_port portRa (
      .addr(ra),
      .regs(regs),
`ifdef REGFILE_BYPASS_EN
      .write(write),
      .we(we),
      .writeData(writeData),
`endif
      .data(readDatara)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file (expectations queued at drive time, popped when outputs settle)
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs, ra, we;
   logic [31:0] writeData;
   logic        write;
   logic [31:0] readDatars, readDatara;
   typedef struct {
      string       tag;
      logic [31:0] exp;
      bit          portB;
   } expT;
   expT         expQ[$];
   logic [31:0] model [32];
   int          assertCount = 0;
   int          failCount = 0;
   register_file dut (
      .clk(clk),
      .rst(rst),
      .rs(rs),
      .ra(ra),
      .we(we),
      .writeData(writeData),
      .write(write),
      .readDatars(readDatars),
      .readDatara(readDatara)
   );
   always #5 clk = ~clk;
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] modelRead(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (write && we != 5'd0 && we == addr) return writeData;
`endif
      return model[addr];
   endfunction
   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask
   task automatic setRead(input string tag, input logic [4:0] a, input logic [4:0] b);
      expT e;
      rs = a;
      ra = b;
      expQ.push_back('{tag: {tag, "/rs"}, exp: modelRead(a), portB: 1'b0});
      expQ.push_back('{tag: {tag, "/ra"}, exp: modelRead(b), portB: 1'b1});
      #1;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkVal(e.tag, e.portB ? readDatara : readDatars, e.exp);
      end
   endtask
   task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
      we = addr;
      writeData = data;
      write = 1'b1;
      @(posedge clk);
      if (rst && addr != 5'd0) model[addr] = data;
      #1;
      write = 1'b0;
   endtask
   initial begin
      rst = 1'b0;
      write = 1'b0;
      we = '0;
      writeData = '0;
      rs = '0;
      ra = '0;
      clearModel();
      #3;
      setRead("inReset", 5'd5, 5'd31);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      doWrite(5'd5, 32'hFFFF_FFFF);
      setRead("r5Written", 5'd5, 5'd5);
      #2;
      rst = 1'b0;
      clearModel();
      setRead("asyncRst", 5'd5, 5'd5);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      we = 5'd6;
      writeData = 32'h0000_00AA;
      write = 1'b1;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      write = 1'b0;
      setRead("rstWinsLow", 5'd6, 5'd6);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      setRead("rstWinsHigh", 5'd6, 5'd6);
      doWrite(5'd3, 32'd128);
      setRead("basic", 5'd3, 5'd3);
      setRead("r4Clean", 5'd4, 5'd3);
      doWrite(5'd0, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         setRead("r0Zero", 5'd0, 5'd0);
         @(posedge clk);
         #1;
      end
      we = 5'd7;
      writeData = 32'd55;
      write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      setRead("weLow", 5'd7, 5'd7);
      we = 5'd9;
      writeData = 32'h0000_1234;
      write = 1'b1;
      setRead("rdwPre", 5'd9, 5'd9);
      setRead("rdwOther", 5'd2, 5'd9);
      @(posedge clk);
      model[9] = 32'h0000_1234;
      #1;
      write = 1'b0;
      setRead("rdwPost", 5'd9, 5'd9);
      for (int i = 1; i < 32; i++) doWrite(5'(i), 32'(i * 4));
      for (int i = 0; i < 32; i++) setRead("sweep", 5'(i), 5'(31 - i));
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
